// File: rtl/serial_sub_if.sv
// ---------------------------------------------------------------------------
// serial_sub_if
//   Operand/result handshake bundle for the bit-serial subtractor.
//   master : producer/consumer side (drives operands and out_ready)
//   slave  : subtractor side (drives in_ready and the result)
// Signals
//   in_valid, in_ready : operand handshake
//   a, b, bin          : minuend, subtrahend, borrow-in
//   out_valid, out_ready : result handshake
//   diff, bout         : difference (mod 2^WIDTH) and borrow-out
// ---------------------------------------------------------------------------
interface serial_sub_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout
    );
endinterface

// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial N-bit subtractor: diff = a - b - bin, one bit per clock, LSB
//   first, using a single full-subtractor cell and a registered borrow.
//   Operands are accepted in IDLE, shifted through the cell for WIDTH cycles
//   in BUSY, and the result is presented in DONE until the consumer takes it.
// Ports
//   clk  : system clock, rising edge
//   rst  : synchronous, active-high reset (priority over all handshakes)
//   bus  : serial_sub_if.slave (operand and result handshakes)
// Parameters
//   WIDTH : operand/result width, 2..32
// Build options
//   SERIAL_SUB_SAT_EN : when defined, a result with final borrow=1 is
//                       saturated to zero; bout still reports the borrow.
// ---------------------------------------------------------------------------
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    serial_sub_if.slave  bus
);
    // One extra bit so the counter can never wrap before reaching WIDTH-1.
    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             brw_q, brw_d;
    logic             bout_q, bout_d;

    // Full-subtractor cell on the current LSBs.
    logic             a0, b0, d_bit, brw_next;
    logic [WIDTH-1:0] r_shift;

    always_comb begin
        a0       = a_q[0];
        b0       = b_q[0];
        d_bit    = a0 ^ b0 ^ brw_q;
        brw_next = (~a0 & b0) | (~(a0 ^ b0) & brw_q);
        r_shift  = {d_bit, r_q[WIDTH-1:1]};
    end

    // NOTE: every signal gets its hold value first so no path through the
    // case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        diff_d  = diff_q;
        cnt_d   = cnt_q;
        brw_d   = brw_q;
        bout_d  = bout_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    brw_d   = bus.bin;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end

            BUSY: begin
                r_d   = r_shift;
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                brw_d = brw_next;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = DONE;
                    bout_d  = brw_next;
`ifdef SERIAL_SUB_SAT_EN
                    // Unsigned saturation: an underflow clamps to zero.
                    diff_d  = brw_next ? '0 : r_shift;
`else
                    diff_d  = r_shift;
`endif
                end
            end

            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: state flops use non-blocking assignments so every flop samples
    // its pre-edge inputs regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            diff_q  <= '0;
            cnt_q   <= '0;
            brw_q   <= 1'b0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            diff_q  <= diff_d;
            cnt_q   <= cnt_d;
            brw_q   <= brw_d;
            bout_q  <= bout_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.diff      = diff_q;
    assign bus.bout      = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// ---------------------------------------------------------------------------
// tb_serial_subtractor
//   Self-checking bench for serial_subtractor (WIDTH=8). A transaction-level
//   model tracks the handshake phases and computes each result arithmetically;
//   a compare process checks all outputs every cycle. Directed operations pin
//   the model with hand-computed literals, then random traffic follows.
// ---------------------------------------------------------------------------
module tb_serial_subtractor;
    localparam int W = 8;

    logic clk;
    logic rst;

    serial_sub_if #(.WIDTH(W)) bus ();

    serial_subtractor #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // phase: 0 = accepting, 1 = computing, 2 = result pending
    int           m_phase = 0;
    int           m_left  = 0;
    logic [W-1:0] m_diff  = '0;
    logic         m_bout  = 1'b0;
    logic [W-1:0] m_pdiff = '0;
    logic         m_pbout = 1'b0;
    int           n_acc   = 0;

    function automatic logic [W:0] ref_sub(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic bin);
        logic [W:0] r;
        r = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
`ifdef SERIAL_SUB_SAT_EN
        if (r[W]) r[W-1:0] = '0;
`endif
        return r;
    endfunction

    always @(posedge clk) begin
        logic [W:0] r;
        if (rst) begin
            m_phase <= 0;
            m_diff  <= '0;
            m_bout  <= 1'b0;
        end else begin
            case (m_phase)
                0: if (bus.in_valid) begin
                    r        = ref_sub(bus.a, bus.b, bus.bin);
                    m_pdiff <= r[W-1:0];
                    m_pbout <= r[W];
                    m_left  <= W;
                    m_phase <= 1;
                    n_acc   <= n_acc + 1;
                end
                1: begin
                    m_left <= m_left - 1;
                    if (m_left == 1) begin
                        m_phase <= 2;
                        m_diff  <= m_pdiff;
                        m_bout  <= m_pbout;
                    end
                end
                default: if (bus.out_ready) m_phase <= 0;
            endcase
        end
    end

    // Compare process: outputs are sampled on the falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_in_ready",  32'(bus.in_ready),  32'(m_phase == 0));
            check("cyc_out_valid", 32'(bus.out_valid), 32'(m_phase == 2));
            check("cyc_diff",      32'(bus.diff),      32'(m_diff));
            check("cyc_bout",      32'(bus.bout),      32'(m_bout));
        end
    end

    // ---------------- directed helpers ----------------
    task automatic idle_inputs();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
    endtask

    // Issue one operation, check latency and result literals, hold DONE for
    // 'hold' cycles with stray in_valid pulses, then release it.
    task automatic do_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic bin, input int hold,
                         input logic [W-1:0] exp_diff, input logic exp_bout);
        int cyc;
        @(negedge clk);
        bus.a = a; bus.b = b; bus.bin = bin;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        cyc = 0;
        while (!bus.out_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check({name, "_latency"}, 32'(cyc), 32'(W));
        check({name, "_diff"}, 32'(bus.diff), 32'(exp_diff));
        check({name, "_bout"}, 32'(bus.bout), 32'(exp_bout));
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = i[0];
            bus.a = 8'hA5; bus.b = 8'h11;
            @(negedge clk);
            check({name, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
            check({name, "_hold_diff"}, 32'(bus.diff), 32'(exp_diff));
            check({name, "_hold_in_ready"}, 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check({name, "_release_valid"}, 32'(bus.out_valid), 32'd0);
        check({name, "_release_in_ready"}, 32'(bus.in_ready), 32'd1);
        bus.out_ready = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int cyc;
        int start_acc;
        logic [W-1:0] ra, rb;

        rst = 1'b1;
        bus.a = '0; bus.b = '0; bus.bin = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;

        // 1. reset values
        check("reset_in_ready",  32'(bus.in_ready),  32'd1);
        check("reset_out_valid", 32'(bus.out_valid), 32'd0);
        check("reset_diff",      32'(bus.diff),      32'h00);
        check("reset_bout",      32'(bus.bout),      32'd0);

        // 2-5. directed operations with hand-computed results
        do_op("t2", 8'h5A, 8'h3C, 1'b0, 0, 8'h1E, 1'b0);
`ifdef SERIAL_SUB_SAT_EN
        do_op("t3", 8'h00, 8'h01, 1'b0, 0, 8'h00, 1'b1);
`else
        do_op("t3", 8'h00, 8'h01, 1'b0, 0, 8'hFF, 1'b1);
`endif
        do_op("t4", 8'h80, 8'h7F, 1'b1, 0, 8'h00, 1'b0);
        do_op("t5", 8'h10, 8'h01, 1'b0, 5, 8'h0F, 1'b0);
        do_op("b0", 8'hC3, 8'h00, 1'b0, 1, 8'hC3, 1'b0);
`ifdef SERIAL_SUB_SAT_EN
        do_op("eq", 8'h6B, 8'h6B, 1'b1, 0, 8'h00, 1'b1);
`else
        do_op("eq", 8'h6B, 8'h6B, 1'b1, 0, 8'hFF, 1'b1);
`endif

        // 6. reset in the middle of an operation
        @(negedge clk);
        bus.a = 8'hFF; bus.b = 8'h0F; bus.bin = 1'b0;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t6_rst_in_ready",  32'(bus.in_ready),  32'd1);
        check("t6_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("t6_rst_diff",      32'(bus.diff),      32'h00);
        check("t6_rst_bout",      32'(bus.bout),      32'd0);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("t6_no_valid", 32'(bus.out_valid), 32'd0);
        end
`ifdef SERIAL_SUB_SAT_EN
        do_op("t6", 8'h03, 8'h05, 1'b0, 0, 8'h00, 1'b1);
`else
        do_op("t6", 8'h03, 8'h05, 1'b0, 0, 8'hFE, 1'b1);
`endif

        // Random traffic: random operands, valid pulses and out_ready stalls.
        start_acc = n_acc;
        cyc = 0;
        while ((n_acc - start_acc) < 1000 && cyc < 60000) begin
            @(negedge clk);
            cyc++;
            ra = W'($urandom);
            rb = W'($urandom);
            case ($urandom_range(0, 7))
                0: rb = '0;
                1: rb = ra;
                2: begin ra = '0; rb = '1; end
                default: ;
            endcase
            bus.a = ra;
            bus.b = rb;
            bus.bin = 1'($urandom);
            bus.in_valid = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 1) != 0);
        end
        check("random_ops_accepted", 32'(n_acc - start_acc), 32'd1000);

        @(negedge clk);
        idle_inputs();
        repeat (W + 3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
